// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver (scan code set 2) producing the 11-bit ps2_key event bus.
// Filters the raw PS/2 clock, frames bytes, and folds E0/F0/E1 prefixes into key events.
module ps2_key_decoder #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 4000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, dat_sync;
    logic          filt, filt_d, fall, dat;
    logic [7:0]    filt_cnt;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    state_t        state, state_nx;
    logic [2:0]    bitcnt;
    logic [7:0]    sh;
    logic          par;
    logic          start_err, bad_frame, good_frame;
    logic          ext, rel, ign;
    logic [2:0]    skip;

    assign dat  = dat_sync[1];
    assign fall = filt_d & ~filt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt     <= 1'b1;
            filt_d   <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            filt_d   <= filt;
            // count consecutive samples disagreeing with the filtered level
            if (clk_sync[1] == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == 8'(FILTER - 1)) begin
                filt     <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 8'd1;
            end
        end
    end

    assign timeout = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)                   to_cnt <= '0;
        else if (fall || state == IDLE) to_cnt <= '0;
        else if (!timeout)              to_cnt <= to_cnt + 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        start_err  = 1'b0;
        bad_frame  = 1'b0;
        good_frame = 1'b0;
        if (timeout) begin
            state_nx = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (dat) start_err = 1'b1;
                         else     state_nx  = DATA;
                DATA:    if (bitcnt == 3'd7) state_nx = PARITY;
                PARITY:  state_nx = STOP;
                STOP: begin
                    state_nx = IDLE;
                    // odd parity across data plus parity bit, stop must be high
                    if (dat && (^{sh, par})) good_frame = 1'b1;
                    else                     bad_frame  = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bitcnt <= '0;
            sh     <= '0;
            par    <= 1'b0;
        end else if (fall && !timeout) begin
            case (state)
                IDLE:    bitcnt <= '0;
                DATA: begin
                    sh     <= {dat, sh[7:1]};
                    bitcnt <= bitcnt + 3'd1;
                end
                PARITY:  par <= dat;
                default: ;
            endcase
        end
    end

    assign ign = (sh == 8'h00) || (sh == 8'hAA) || (sh == 8'hEE) ||
                 (sh == 8'hFA) || (sh == 8'hFE) || (sh == 8'hFF);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ps2_key   <= '0;
            frame_err <= 1'b0;
            ext       <= 1'b0;
            rel       <= 1'b0;
            skip      <= '0;
        end else begin
            frame_err <= start_err | bad_frame | timeout;
            if (timeout) begin
                ext <= 1'b0;
                rel <= 1'b0;
            end else if (good_frame) begin
                // Pause (E1 ...) is eight bytes long: swallow the seven after E1
                if (skip != 3'd0)       skip <= skip - 3'd1;
                else if (sh == 8'hE1)   skip <= 3'd7;
                else if (sh == 8'hE0)   ext  <= 1'b1;
                else if (sh == 8'hF0)   rel  <= 1'b1;
                else if (!(ign && !ext && !rel)) begin
                    ps2_key <= {~ps2_key[10], ~rel, ext, sh};
                    ext     <= 1'b0;
                    rel     <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed PS/2 frames plus random traffic, scored
// against a byte-level model of the key event rules.
module tb_ps2_key_decoder;
    localparam int FILTER  = 4;
    localparam int TIMEOUT = 100;
    localparam int H       = 20;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    ps2_key_decoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .frame_err(frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit          is_err;
        logic [10:0] key;
    } ev_t;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int unsigned stop_cyc = 0;
    ev_t         exp_q[$];
    ev_t         head;
    logic [10:0] m_key = '0;
    bit          m_ext = 0, m_rel = 0;
    int          m_skip = 0;
    logic [10:0] prev_key = '0;
    int          lat;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push_err();
        ev_t e;
        e.is_err = 1'b1;
        e.key    = '0;
        exp_q.push_back(e);
    endtask

    // byte-level rules: prefixes, Pause swallowing, ignored control codes
    task automatic m_byte(input logic [7:0] b);
        ev_t e;
        bit  ctl;
        ctl = (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
              (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
        if (m_skip > 0)          m_skip--;
        else if (b == 8'hE1)     m_skip = 7;
        else if (b == 8'hE0)     m_ext = 1;
        else if (b == 8'hF0)     m_rel = 1;
        else if (ctl && !m_ext && !m_rel) begin
        end else begin
            m_key    = {~m_key[10], ~m_rel, m_ext, b};
            m_ext    = 0;
            m_rel    = 0;
            e.is_err = 1'b0;
            e.key    = m_key;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_key = '0;
        end else begin
            if (frame_err === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL frame_err: got pulse want no event");
                end else begin
                    head = exp_q.pop_front();
                    if (!head.is_err) begin
                        bad++;
                        $display("FAIL frame_err: got pulse want key %0h", head.key);
                    end
                end
            end
            if (ps2_key !== prev_key) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL key_event: got %0h want no event", ps2_key);
                end else begin
                    head = exp_q.pop_front();
                    if (head.is_err || ps2_key !== head.key) begin
                        bad++;
                        $display("FAIL key_event: got %0h want %0h (err=%0d)", ps2_key, head.key, head.is_err);
                    end
                end
                lat = int'(cyc - stop_cyc);
                total++;
                if (lat < FILTER + 2 || lat > FILTER + 4) begin
                    bad++;
                    $display("FAIL key_latency: got %0d want %0d..%0d", lat, FILTER + 2, FILTER + 4);
                end
            end
            prev_key = ps2_key;
        end
    end

    task automatic bit_fall(input logic d, input bit glitch);
        @(negedge clk_sys);
        ps2_data = d;
        if (glitch) begin
            repeat (2) @(negedge clk_sys);
            ps2_clk = 1'b0;
            repeat (FILTER - 1) @(negedge clk_sys);
            ps2_clk = 1'b1;
            repeat (H - 2 - (FILTER - 1)) @(negedge clk_sys);
        end else begin
            repeat (H) @(negedge clk_sys);
        end
        ps2_clk = 1'b0;
    endtask

    task automatic bit_rise();
        repeat (H) @(negedge clk_sys);
        ps2_clk = 1'b1;
    endtask

    task automatic drain(input int wait_cyc);
        repeat (wait_cyc) @(negedge clk_sys);
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int glitch_at);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bit_fall(fr[i], i == glitch_at);
            if (i == 10) begin
                stop_cyc = cyc;
                if (bad_par || bad_stop) push_err();
                else                     m_byte(b);
            end
            bit_rise();
        end
        @(negedge clk_sys);
        ps2_data = 1'b1;
        drain(10);
    endtask

    task automatic send_timeout();
        bit_fall(1'b0, 0);
        bit_rise();
        for (int i = 0; i < 4; i++) begin
            bit_fall(1'($urandom_range(0, 1)), 0);
            bit_rise();
        end
        push_err();
        m_ext = 0;
        m_rel = 0;
        @(negedge clk_sys);
        ps2_data = 1'b1;
        drain(TIMEOUT + 10);
    endtask

    task automatic send_start_err();
        bit_fall(1'b1, 0);
        push_err();
        bit_rise();
        drain(10);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        logic [7:0] ctl_codes [6];
        ctl_codes = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

        repeat (3) @(negedge clk_sys);
        chk("reset_key", ps2_key, 11'h000);
        chk("reset_err", frame_err, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);

        send_frame(8'h1C, 0, 0, -1);
        chk("pin_press_1c", m_key, 11'h61C);
        chk("dut_press_1c", ps2_key, 11'h61C);
        send_frame(8'hF0, 0, 0, -1);
        chk("no_out_on_f0", ps2_key, 11'h61C);
        send_frame(8'h1C, 0, 0, -1);
        chk("pin_release_1c", m_key, 11'h01C);

        send_frame(8'hE0, 0, 0, -1);
        send_frame(8'h75, 0, 0, -1);
        chk("pin_ext_press", m_key, 11'h775);
        send_frame(8'hE0, 0, 0, -1);
        send_frame(8'hF0, 0, 0, -1);
        send_frame(8'h75, 0, 0, -1);
        chk("pin_ext_release", m_key, 11'h175);

        send_frame(8'h1C, 1, 0, -1);
        chk("bad_parity_hold", ps2_key, 11'h175);
        send_frame(8'h29, 0, 0, -1);
        chk("pin_after_err", m_key, 11'h629);

        send_timeout();
        send_frame(8'h14, 0, 0, -1);
        chk("pin_after_timeout", m_key, 11'h214);

        send_frame(8'hE1, 0, 0, -1);
        send_frame(8'h14, 0, 0, -1);
        send_frame(8'h77, 0, 0, -1);
        send_frame(8'hE1, 0, 0, -1);
        send_frame(8'hF0, 0, 0, -1);
        send_frame(8'h14, 0, 0, -1);
        send_frame(8'hF0, 0, 0, -1);
        send_frame(8'h77, 0, 0, -1);
        chk("pause_no_update", ps2_key, 11'h214);
        send_frame(8'h05, 0, 0, -1);
        chk("pin_after_pause", m_key, 11'h605);

        send_frame(8'h33, 0, 0, 4);
        chk("pin_glitch", m_key, 11'h233);
        send_frame(8'hAA, 0, 0, -1);
        chk("ctl_ignored", ps2_key, 11'h233);
        send_frame(8'h44, 0, 1, -1);
        send_start_err();

        // abandon a frame part-way through with a reset
        bit_fall(1'b0, 0);
        bit_rise();
        for (int i = 0; i < 3; i++) begin
            bit_fall(1'b1, 0);
            bit_rise();
        end
        @(negedge clk_sys);
        reset_n = 1'b0;
        m_key = '0; m_ext = 0; m_rel = 0; m_skip = 0;
        exp_q.delete();
        repeat (3) @(negedge clk_sys);
        chk("midframe_reset_key", ps2_key, 11'h000);
        chk("midframe_reset_err", frame_err, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        send_frame(8'h1C, 0, 0, -1);
        chk("pin_post_reset", m_key, 11'h61C);

        for (int n = 0; n < 60; n++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                send_timeout();
            end else if (r == 1) begin
                send_start_err();
            end else begin
                r = $urandom_range(0, 9);
                case (r)
                    0:       b = 8'hE0;
                    1:       b = 8'hF0;
                    2:       b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'($urandom);
                    3:       b = ctl_codes[$urandom_range(0, 5)];
                    default: b = 8'($urandom);
                endcase
                send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                           ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : -1);
            end
        end

        drain(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
